morse_stream_decoder: RTL
=========================

# morse_stream_decoder

Clocked, parametrised successor to the combinational five-slot Morse decoder. It accepts Morse symbols one at a time from the key/timing front end and accumulates up to MAX_SYMBOLS per letter. On a letter or word boundary it decodes the letter to 8-bit ASCII and queues the character in an output FIFO for the display/UART stage through a valid/ready handshake. It adds behaviour the fixed-slot decoder lacks: serial input, patterns longer than five symbols, punctuation, word spacing, error marking and buffering.

## Interface
- MAX_SYMBOLS, 6, symbols held per letter; legal range 5..8
- FIFO_DEPTH, 4, output character FIFO depth; power of two, 2..16
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- sym_valid  input  1  one-cycle strobe: sym carries a symbol
- sym  input  2  symbol code: 2'b01 dot, 2'b10 dash; 2'b00 and 2'b11 are illegal
- letter_done  input  1  one-cycle strobe: current letter is complete
- word_done  input  1  one-cycle strobe: word gap; also closes the current letter
- ascii_char  output  8  FIFO head character; valid only while char_valid is 1
- char_valid  output  1  FIFO not empty
- char_ready  input  1  consumer accepts the head character when char_valid and char_ready are both 1
- sym_error  output  1  sticky: illegal symbol or letter overflow seen; cleared only by reset
- fifo_overflow  output  1  sticky: a character was dropped because the FIFO was full; cleared only by reset
- busy  output  1  a letter is partially collected (sym_cnt != 0) or a space is pending

## Operation
- Letter buffer:
  - sym_cnt runs 0..MAX_SYMBOLS.
  - dash_bits is MAX_SYMBOLS wide, one bit per symbol, 1 = dash. Symbol k (0 = first) is stored at bit k.
  - An illegal flag marks the letter as bad.
- Legal sym_valid with sym_cnt < MAX_SYMBOLS: store the symbol at bit sym_cnt and increment sym_cnt.
- sym_valid when sym_cnt == MAX_SYMBOLS: do not store; set the letter-bad flag and sym_error.
- Illegal sym code: do not store or count; set the letter-bad flag and sym_error.
- Decode, at the close of a letter with sym_cnt > 0:
  - A–Z produce uppercase 0x41–0x5A; 0–9 produce 0x30–0x39.
  - '.' = .-.-.- gives 0x2E; ',' = --..-- gives 0x2C; '?' = ..--.. gives 0x3F. These only decode when MAX_SYMBOLS >= 6.
  - An unknown pattern or a letter-bad letter gives 0x3F.
- Letter close with sym_cnt == 0: push nothing.
- Same-cycle sym_valid and letter_done: the symbol is included in the letter being closed.
- State machine:
  - IDLE (sym_cnt = 0) -> COLLECT on a legal or illegal sym_valid.
  - COLLECT -> IDLE on letter_done: push the decoded character and clear the letter buffer.
  - COLLECT or IDLE -> SPACE_PEND on word_done: any collected letter is pushed that cycle.
  - SPACE_PEND -> IDLE the next cycle, pushing 0x20.
- Space suppression: 0x20 is pushed only if at least one non-space character has been pushed since reset and the last pushed character was not 0x20.
- sym_valid arriving in SPACE_PEND starts the next letter normally; the space is still pushed.
- letter_done and word_done in the same cycle are treated as word_done.
- FIFO:
  - Show-ahead: ascii_char shows the head entry.
  - A push is accepted if the FIFO is not full, or if it is full and a pop happens the same cycle.
  - Otherwise the character is dropped and fifo_overflow is set.
  - Pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (asynchronous assert):
  - ascii_char = 8'h00, char_valid = 0, sym_error = 0, fifo_overflow = 0, busy = 0.
  - FIFO empty, state IDLE, sym_cnt = 0.
- Latency:
  - letter_done in cycle N: character written at edge N; char_valid = 1 and ascii_char correct in cycle N+1 (FIFO was empty).
  - word_done in cycle N: any letter is visible in N+1; the space is written at edge N+1 and reaches the head after the letter is popped.
- Handshake:
  - ascii_char is stable while char_valid = 1 and char_ready = 0.
  - A pop at edge M shows the next entry in cycle M+1, or drops char_valid if that was the last entry.
- Reset mid-letter or with the FIFO non-empty discards all content immediately.
- Strobes are sampled every cycle; back-to-back symbols at one per cycle are supported.

## Test plan
- Single letters: dot,dash + letter_done gives 0x41 one cycle later; dash,dash,dash,dash,dot + letter_done gives 0x39; ..--.. gives 0x3F with sym_error = 0.
- Sweep all 36 A–Z/0–9 patterns back to back with char_ready = 1 -> 36 characters in order, no overflow.
- Word: "E" (dot), word_done, "T" (dash), word_done, word_done -> 0x45, 0x20, 0x54, 0x20. The second consecutive space is suppressed. A word_done straight after reset pushes nothing.
- Errors:
  - Seven dots with MAX_SYMBOLS = 6 -> 0x3F, sym_error = 1.
  - sym = 2'b11 then dot + letter_done -> 0x3F, sym_error = 1.
  - letter_done with sym_cnt = 0 -> no push.
- FIFO (FIFO_DEPTH = 4) with char_ready = 0:
  - Push 5 letters -> first 4 retained, fifo_overflow = 1.
  - Full FIFO with simultaneous pop and push -> no drop.
  - Pointer wrap over 10 letters preserves order.
- Reset asserted asynchronously mid-letter with 3 characters queued -> all outputs return to reset values without waiting for a clock edge; the next letter decodes cleanly.

Source files
------------

// File: rtl/morse_stream_decoder.sv
// Serial Morse symbol decoder.
// Collects dot/dash symbols into a letter buffer and decodes the letter to ASCII
// when the letter or word closes. Characters and word spaces are queued in a
// show-ahead FIFO that is drained through a valid/ready handshake.
module morse_stream_decoder #(
  parameter int MAX_SYMBOLS = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [1:0] sym,
  input  logic       letter_done,
  input  logic       word_done,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       sym_error,
  output logic       fifo_overflow,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_SYMBOLS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_SPACE_PEND
  } state_e;

  // Letter table: n = symbol count, b = dash bits with the first symbol at bit 0.
  function automatic logic [7:0] decode_letter(input logic [3:0] n,
                                               input logic [7:0] b,
                                               input logic       bad);
    logic [7:0] c;
    c = 8'h3F;
    case (n)
      4'd1: c = b[0] ? 8'h54 : 8'h45;
      4'd2: case (b[1:0])
        2'b10: c = 8'h41;
        2'b00: c = 8'h49;
        2'b11: c = 8'h4D;
        2'b01: c = 8'h4E;
        default: ;
      endcase
      4'd3: case (b[2:0])
        3'b001: c = 8'h44;
        3'b011: c = 8'h47;
        3'b101: c = 8'h4B;
        3'b111: c = 8'h4F;
        3'b010: c = 8'h52;
        3'b000: c = 8'h53;
        3'b100: c = 8'h55;
        3'b110: c = 8'h57;
        default: ;
      endcase
      4'd4: case (b[3:0])
        4'b0001: c = 8'h42;
        4'b0101: c = 8'h43;
        4'b0100: c = 8'h46;
        4'b0000: c = 8'h48;
        4'b1110: c = 8'h4A;
        4'b0010: c = 8'h4C;
        4'b0110: c = 8'h50;
        4'b1011: c = 8'h51;
        4'b1000: c = 8'h56;
        4'b1001: c = 8'h58;
        4'b1101: c = 8'h59;
        4'b0011: c = 8'h5A;
        default: ;
      endcase
      4'd5: case (b[4:0])
        5'b11111: c = 8'h30;
        5'b11110: c = 8'h31;
        5'b11100: c = 8'h32;
        5'b11000: c = 8'h33;
        5'b10000: c = 8'h34;
        5'b00000: c = 8'h35;
        5'b00001: c = 8'h36;
        5'b00011: c = 8'h37;
        5'b00111: c = 8'h38;
        5'b01111: c = 8'h39;
        default: ;
      endcase
      4'd6: if (MAX_SYMBOLS >= 6) begin
        case (b[5:0])
          6'b101010: c = 8'h2E;
          6'b110011: c = 8'h2C;
          6'b001100: c = 8'h3F;
          default: ;
        endcase
      end
      default: ;
    endcase
    if (bad) c = 8'h3F;
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MAX_SYMBOLS-1:0] bits_q, bits_d;
  logic                   bad_q, bad_d;
  logic                   cls_pend_q, cls_pend_d;
  logic                   wrd_pend_q, wrd_pend_d;
  logic                   any_char_q, any_char_d;
  logic                   last_sp_q, last_sp_d;
  logic                   sym_err_q, sym_err_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  logic                   sym_legal, at_max, store, bad_now;
  logic [MAX_SYMBOLS-1:0] one_hot, bits_a;
  logic [CNT_W-1:0]       cnt_a;
  logic                   bad_a, ld_eff, wd_eff;
  logic                   push_req, push_ok, pop, full;
  logic [7:0]             push_data;

  // Next-state for the letter buffer, state machine, space logic and FIFO pointers.
  always_comb begin
    sym_legal = (sym == 2'b01) || (sym == 2'b10);
    at_max    = (cnt_q == CNT_W'(MAX_SYMBOLS));
    store     = sym_valid && sym_legal && !at_max;
    bad_now   = sym_valid && (!sym_legal || at_max);
    one_hot   = {{(MAX_SYMBOLS-1){1'b0}}, 1'b1} << cnt_q;
    cnt_a     = cnt_q + CNT_W'(store);
    bits_a    = (store && sym == 2'b10) ? (bits_q | one_hot) : bits_q;
    bad_a     = bad_q | bad_now;
    // A close that collided with a space push is replayed one cycle later.
    ld_eff    = letter_done | cls_pend_q;
    wd_eff    = word_done | wrd_pend_q;

    push_req   = 1'b0;
    push_data  = 8'h00;
    cnt_d      = cnt_a;
    bits_d     = bits_a;
    bad_d      = bad_a;
    cls_pend_d = 1'b0;
    wrd_pend_d = 1'b0;
    state_d    = state_q;

    case (state_q)
      ST_SPACE_PEND: begin
        if (any_char_q && !last_sp_q) begin
          push_req  = 1'b1;
          push_data = 8'h20;
        end
        if ((letter_done || word_done) && cnt_a != '0) begin
          cls_pend_d = 1'b1;
          wrd_pend_d = word_done;
        end else if (letter_done || word_done) begin
          bad_d = 1'b0;
        end
        state_d = (cnt_a != '0 || bad_a) ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        if (ld_eff || wd_eff) begin
          if (cnt_a != '0) begin
            push_req  = 1'b1;
            push_data = decode_letter(4'(cnt_a), 8'(bits_a), bad_a);
          end
          cnt_d   = '0;
          bits_d  = '0;
          bad_d   = 1'b0;
          state_d = wd_eff ? ST_SPACE_PEND : ST_IDLE;
        end else begin
          state_d = (cnt_a != '0 || bad_a) ? ST_COLLECT : ST_IDLE;
        end
      end
    endcase

    pop      = (occ_q != '0) && char_ready;
    full     = (occ_q == OCC_W'(FIFO_DEPTH));
    push_ok  = push_req && (!full || pop);
    ovf_d    = ovf_q | (push_req && !push_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + OCC_W'(push_ok) - OCC_W'(pop);

    // Space suppression tracks every character offered to the FIFO.
    any_char_d = any_char_q | (push_req && push_data != 8'h20);
    last_sp_d  = push_req ? (push_data == 8'h20) : last_sp_q;
    sym_err_d  = sym_err_q | bad_now;
    busy_d     = (cnt_d != '0) || (state_d == ST_SPACE_PEND) || cls_pend_d;
  end

  // Control state and sticky flags, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      bad_q      <= 1'b0;
      cls_pend_q <= 1'b0;
      wrd_pend_q <= 1'b0;
      any_char_q <= 1'b0;
      last_sp_q  <= 1'b0;
      sym_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      bad_q      <= bad_d;
      cls_pend_q <= cls_pend_d;
      wrd_pend_q <= wrd_pend_d;
      any_char_q <= any_char_d;
      last_sp_q  <= last_sp_d;
      sym_err_q  <= sym_err_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // Character storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign char_valid    = (occ_q != '0);
  assign ascii_char    = char_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign sym_error     = sym_err_q;
  assign fifo_overflow = ovf_q;
  assign busy          = busy_q;

endmodule
